// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared SPU constants, nop encoding and operand typedefs
package spu_pkg;

  localparam int REG_COUNT     = 128;
  localparam int QW_BITS       = 128;
  localparam int REG_ADDR_BITS = 7;

  typedef logic [QW_BITS-1:0]         qword_t;
  typedef logic [0:REG_ADDR_BITS-1]   reg_addr_t;
  typedef logic [0:10]                op_t;
  typedef logic [2:0]                 format_t;
  typedef logic [0:17]                imm_t;

  // op = 0 with format = 0 is the canonical nop; downstream never stores on it
  localparam op_t     NOP_OP     = '0;
  localparam format_t NOP_FORMAT = '0;

endpackage

// File: rtl/fwd_mux.sv
// rtl/fwd_mux.sv - priority operand selector: youngest tap, odd wb, even wb, table
module fwd_mux
  import spu_pkg::*;
#(
  parameter int FW_SRCS = 4
) (
  input  reg_addr_t                                src_addr,
  input  logic [FW_SRCS-1:0][QW_BITS-1:0]          fw_data,
  input  logic [FW_SRCS-1:0][0:REG_ADDR_BITS-1]    fw_addr,
  input  logic [FW_SRCS-1:0]                       fw_valid,
  input  qword_t                                   odd_rt_wb,
  input  reg_addr_t                                odd_rt_addr_wb,
  input  logic                                     odd_reg_write_wb,
  input  qword_t                                   even_rt_wb,
  input  reg_addr_t                                even_rt_addr_wb,
  input  logic                                     even_reg_write_wb,
  input  qword_t                                   table_data,
  output qword_t                                   result
);

  // Lowest priority is assigned first so each later hit overrides it
  always_comb begin
    result = table_data;
    if (even_reg_write_wb && (even_rt_addr_wb == src_addr)) begin
      result = even_rt_wb;
    end
    if (odd_reg_write_wb && (odd_rt_addr_wb == src_addr)) begin
      result = odd_rt_wb;
    end
    for (int k = FW_SRCS - 1; k >= 0; k--) begin
      if (fw_valid[k] && (fw_addr[k] == src_addr)) begin
        result = fw_data[k];
      end
    end
  end

endmodule

// File: rtl/odd_rf_fwd.sv
// rtl/odd_rf_fwd.sv - odd pipe register fetch with RAW forwarding and output register
module odd_rf_fwd
  import spu_pkg::*;
#(
  parameter int FW_SRCS = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     stall,
  input  logic                                     branch_taken,
  input  logic [0:10]                              op_in,
  input  logic [2:0]                               format_in,
  input  logic [0:17]                              imm_in,
  input  logic [0:6]                               rt_addr_in,
  input  logic                                     reg_write_in,
  input  logic [0:6]                               ra_addr,
  input  logic [0:6]                               rb_addr,
  input  logic [0:6]                               rc_addr,
  input  logic [FW_SRCS-1:0][QW_BITS-1:0]          fw_data,
  input  logic [FW_SRCS-1:0][0:REG_ADDR_BITS-1]    fw_addr,
  input  logic [FW_SRCS-1:0]                       fw_valid,
  input  logic [127:0]                             odd_rt_wb,
  input  logic [127:0]                             even_rt_wb,
  input  logic [0:6]                               odd_rt_addr_wb,
  input  logic [0:6]                               even_rt_addr_wb,
  input  logic                                     odd_reg_write_wb,
  input  logic                                     even_reg_write_wb,
  output logic [0:10]                              op,
  output logic [2:0]                               format,
  output logic [0:17]                              imm,
  output logic [0:6]                               rt_addr,
  output logic                                     reg_write,
  output logic [127:0]                             ra,
  output logic [127:0]                             rb,
  output logic [127:0]                             rt_st
);

  qword_t    regs_q [REG_COUNT];
  qword_t    regs_d [REG_COUNT];

  op_t       op_q, op_d;
  format_t   format_q, format_d;
  imm_t      imm_q, imm_d;
  reg_addr_t rt_addr_q, rt_addr_d;
  logic      reg_write_q, reg_write_d;
  qword_t    ra_q, ra_d;
  qword_t    rb_q, rb_d;
  qword_t    rt_st_q, rt_st_d;

  qword_t    ra_fwd, rb_fwd, rc_fwd;

  // Odd port is applied last so it wins a same-address collision with even
  always_comb begin
    regs_d = regs_q;
    if (even_reg_write_wb) begin
      regs_d[even_rt_addr_wb] = even_rt_wb;
    end
    if (odd_reg_write_wb) begin
      regs_d[odd_rt_addr_wb] = odd_rt_wb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  fwd_mux #(.FW_SRCS(FW_SRCS)) u_fwd_ra (
    .src_addr          (ra_addr),
    .fw_data           (fw_data),
    .fw_addr           (fw_addr),
    .fw_valid          (fw_valid),
    .odd_rt_wb         (odd_rt_wb),
    .odd_rt_addr_wb    (odd_rt_addr_wb),
    .odd_reg_write_wb  (odd_reg_write_wb),
    .even_rt_wb        (even_rt_wb),
    .even_rt_addr_wb   (even_rt_addr_wb),
    .even_reg_write_wb (even_reg_write_wb),
    .table_data        (regs_q[ra_addr]),
    .result            (ra_fwd)
  );

  fwd_mux #(.FW_SRCS(FW_SRCS)) u_fwd_rb (
    .src_addr          (rb_addr),
    .fw_data           (fw_data),
    .fw_addr           (fw_addr),
    .fw_valid          (fw_valid),
    .odd_rt_wb         (odd_rt_wb),
    .odd_rt_addr_wb    (odd_rt_addr_wb),
    .odd_reg_write_wb  (odd_reg_write_wb),
    .even_rt_wb        (even_rt_wb),
    .even_rt_addr_wb   (even_rt_addr_wb),
    .even_reg_write_wb (even_reg_write_wb),
    .table_data        (regs_q[rb_addr]),
    .result            (rb_fwd)
  );

  fwd_mux #(.FW_SRCS(FW_SRCS)) u_fwd_rc (
    .src_addr          (rc_addr),
    .fw_data           (fw_data),
    .fw_addr           (fw_addr),
    .fw_valid          (fw_valid),
    .odd_rt_wb         (odd_rt_wb),
    .odd_rt_addr_wb    (odd_rt_addr_wb),
    .odd_reg_write_wb  (odd_reg_write_wb),
    .even_rt_wb        (even_rt_wb),
    .even_rt_addr_wb   (even_rt_addr_wb),
    .even_reg_write_wb (even_reg_write_wb),
    .table_data        (regs_q[rc_addr]),
    .result            (rc_fwd)
  );

  // Stall outranks flush: a flush seen during a stall is dropped
  always_comb begin
    op_d        = op_q;
    format_d    = format_q;
    imm_d       = imm_q;
    rt_addr_d   = rt_addr_q;
    reg_write_d = reg_write_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    rt_st_d     = rt_st_q;
    if (!stall) begin
      if (branch_taken) begin
        op_d        = NOP_OP;
        format_d    = NOP_FORMAT;
        imm_d       = '0;
        rt_addr_d   = '0;
        reg_write_d = 1'b0;
        ra_d        = '0;
        rb_d        = '0;
        rt_st_d     = '0;
      end else begin
        op_d        = op_in;
        format_d    = format_in;
        imm_d       = imm_in;
        rt_addr_d   = rt_addr_in;
        reg_write_d = reg_write_in;
        ra_d        = ra_fwd;
        rb_d        = rb_fwd;
        rt_st_d     = rc_fwd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= NOP_OP;
      format_q    <= NOP_FORMAT;
      imm_q       <= '0;
      rt_addr_q   <= '0;
      reg_write_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rt_st_q     <= '0;
    end else begin
      op_q        <= op_d;
      format_q    <= format_d;
      imm_q       <= imm_d;
      rt_addr_q   <= rt_addr_d;
      reg_write_q <= reg_write_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rt_st_q     <= rt_st_d;
    end
  end

  assign op        = op_q;
  assign format    = format_q;
  assign imm       = imm_q;
  assign rt_addr   = rt_addr_q;
  assign reg_write = reg_write_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign rt_st     = rt_st_q;

endmodule

// File: tb/tb_odd_rf_fwd.sv
// tb/tb_odd_rf_fwd.sv - self-checking bench for odd_rf_fwd against a behavioural model
module tb_odd_rf_fwd;

  localparam int FW = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               stall, branch_taken;
  logic [0:10]        op_in;
  logic [2:0]         format_in;
  logic [0:17]        imm_in;
  logic [0:6]         rt_addr_in;
  logic               reg_write_in;
  logic [0:6]         ra_addr, rb_addr, rc_addr;
  logic [FW-1:0][127:0] fw_data;
  logic [FW-1:0][0:6]   fw_addr;
  logic [FW-1:0]      fw_valid;
  logic [127:0]       odd_rt_wb, even_rt_wb;
  logic [0:6]         odd_rt_addr_wb, even_rt_addr_wb;
  logic               odd_reg_write_wb, even_reg_write_wb;
  logic [0:10]        op;
  logic [2:0]         format;
  logic [0:17]        imm;
  logic [0:6]         rt_addr;
  logic               reg_write;
  logic [127:0]       ra, rb, rt_st;

  typedef struct packed {
    logic [0:10]  op;
    logic [2:0]   fmt;
    logic [0:17]  imm;
    logic [0:6]   rt;
    logic         rw;
    logic [127:0] ra;
    logic [127:0] rb;
    logic [127:0] st;
  } out_t;

  out_t         act, exp_cur, exp_next;
  logic [127:0] mdl [128];
  int           total = 0;
  int           bad = 0;
  bit           chk_en = 0;

  assign act = {op, format, imm, rt_addr, reg_write, ra, rb, rt_st};

  odd_rf_fwd #(.FW_SRCS(FW)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .op_in             (op_in),
    .format_in         (format_in),
    .imm_in            (imm_in),
    .rt_addr_in        (rt_addr_in),
    .reg_write_in      (reg_write_in),
    .ra_addr           (ra_addr),
    .rb_addr           (rb_addr),
    .rc_addr           (rc_addr),
    .fw_data           (fw_data),
    .fw_addr           (fw_addr),
    .fw_valid          (fw_valid),
    .odd_rt_wb         (odd_rt_wb),
    .even_rt_wb        (even_rt_wb),
    .odd_rt_addr_wb    (odd_rt_addr_wb),
    .even_rt_addr_wb   (even_rt_addr_wb),
    .odd_reg_write_wb  (odd_reg_write_wb),
    .even_reg_write_wb (even_reg_write_wb),
    .op                (op),
    .format            (format),
    .imm               (imm),
    .rt_addr           (rt_addr),
    .reg_write         (reg_write),
    .ra                (ra),
    .rb                (rb),
    .rt_st             (rt_st)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rand_qw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // First matching source in priority order, read from the model table last
  function automatic logic [127:0] resolve(logic [0:6] a);
    for (int k = 0; k < FW; k++) begin
      if (fw_valid[k] && fw_addr[k] == a) return fw_data[k];
    end
    if (odd_reg_write_wb && odd_rt_addr_wb == a) return odd_rt_wb;
    if (even_reg_write_wb && even_rt_addr_wb == a) return even_rt_wb;
    return mdl[a];
  endfunction

  task automatic clear_inputs();
    stall = 0; branch_taken = 0;
    op_in = '0; format_in = '0; imm_in = '0; rt_addr_in = '0; reg_write_in = 0;
    ra_addr = '0; rb_addr = '0; rc_addr = '0;
    fw_data = '0; fw_addr = '0; fw_valid = '0;
    odd_rt_wb = '0; even_rt_wb = '0; odd_rt_addr_wb = '0; even_rt_addr_wb = '0;
    odd_reg_write_wb = 0; even_reg_write_wb = 0;
  endtask

  // Called just after a falling edge with inputs set; returns at the next falling edge
  task automatic tick();
    if (stall) exp_next = exp_cur;
    else if (branch_taken) exp_next = '0;
    else exp_next = {op_in, format_in, imm_in, rt_addr_in, reg_write_in,
                     resolve(ra_addr), resolve(rb_addr), resolve(rc_addr)};
    @(posedge clk);
    exp_cur = exp_next;
    if (even_reg_write_wb) mdl[even_rt_addr_wb] = even_rt_wb;
    if (odd_reg_write_wb) mdl[odd_rt_addr_wb] = odd_rt_wb;
    @(negedge clk);
  endtask

  task automatic check(string name, logic [127:0] got, logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (act !== exp_cur) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got op=%h fmt=%h imm=%h rt=%h rw=%b ra=%h rb=%h st=%h want op=%h fmt=%h imm=%h rt=%h rw=%b ra=%h rb=%h st=%h",
                 $time, act.op, act.fmt, act.imm, act.rt, act.rw, act.ra, act.rb, act.st,
                 exp_cur.op, exp_cur.fmt, exp_cur.imm, exp_cur.rt, exp_cur.rw,
                 exp_cur.ra, exp_cur.rb, exp_cur.st);
      end
    end
  end

  initial begin
    logic [0:10] stqd_op;
    stqd_op = 11'b00100100000;
    clear_inputs();
    for (int i = 0; i < 128; i++) mdl[i] = '0;
    exp_cur = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {8'h0, act[$bits(out_t)-1:384]}, 128'h0);
    rst_n = 1;
    chk_en = 1;

    // odd writeback forwarded in the same cycle, then read back from the table
    odd_reg_write_wb = 1; odd_rt_addr_wb = 7'd10; odd_rt_wb = {32{4'hA}};
    ra_addr = 7'd10; op_in = 11'd5; reg_write_in = 1; rt_addr_in = 7'd11;
    tick();
    check("wb_fwd_ra", ra, {32{4'hA}});
    check("wb_fwd_op", {117'h0, op}, 128'd5);
    odd_reg_write_wb = 0;
    tick();
    check("table_read_ra", ra, {32{4'hA}});

    // lowest valid tap index wins
    fw_valid = 4'b0110; fw_addr[1] = 7'd20; fw_addr[2] = 7'd20;
    fw_data[1] = 128'd1; fw_data[2] = 128'd2; rb_addr = 7'd20;
    tick();
    check("tap_priority_rb", rb, 128'd1);
    fw_valid = '0;

    // simultaneous even/odd writes to the same register
    even_reg_write_wb = 1; even_rt_addr_wb = 7'd30; even_rt_wb = 128'd3;
    odd_reg_write_wb = 1; odd_rt_addr_wb = 7'd30; odd_rt_wb = 128'd4;
    ra_addr = 7'd0;
    tick();
    even_reg_write_wb = 0; odd_reg_write_wb = 0;
    ra_addr = 7'd30;
    tick();
    check("wb_collision_ra", ra, 128'd4);

    // flush a store
    op_in = stqd_op; format_in = 3'd3; reg_write_in = 0; rc_addr = 7'd30; branch_taken = 1;
    tick();
    branch_taken = 0;
    check("flush_op", {117'h0, op}, 128'h0);
    check("flush_fmt", {125'h0, format}, 128'h0);
    check("flush_rw", {127'h0, reg_write}, 128'h0);
    check("flush_st", rt_st, 128'h0);

    // stall: outputs frozen, write during stall seen after release
    op_in = 11'd7; format_in = 3'd1; ra_addr = 7'd10;
    tick();
    stall = 1;
    for (int c = 0; c < 3; c++) begin
      op_in = 11'(c + 100); ra_addr = 7'(c);
      odd_reg_write_wb = (c == 1); odd_rt_addr_wb = 7'd40; odd_rt_wb = 128'h1234;
      branch_taken = (c == 2);
      tick();
      check("stall_ra", ra, {32{4'hA}});
      check("stall_op", {117'h0, op}, 128'd7);
    end
    stall = 0; branch_taken = 0; odd_reg_write_wb = 0;
    ra_addr = 7'd40; op_in = 11'd9;
    tick();
    check("post_stall_ra", ra, 128'h1234);

    // asynchronous reset mid-cycle
    #2;
    rst_n = 0;
    #1;
    check("async_rst_ra", ra, 128'h0);
    check("async_rst_op", {117'h0, op}, 128'h0);
    exp_cur = '0;
    for (int i = 0; i < 128; i++) mdl[i] = '0;
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    ra_addr = 7'd5; rb_addr = 7'd10;
    tick();
    check("post_rst_r5", ra, 128'h0);
    check("post_rst_r10", rb, 128'h0);

    // randomized traffic over a small address window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 5) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      op_in = 11'($urandom); format_in = 3'($urandom); imm_in = 18'($urandom);
      rt_addr_in = 7'($urandom_range(0, 7)); reg_write_in = 1'($urandom);
      ra_addr = 7'($urandom_range(0, 7));
      rb_addr = 7'($urandom_range(0, 7));
      rc_addr = 7'($urandom_range(0, 7));
      for (int k = 0; k < FW; k++) begin
        fw_data[k] = rand_qw();
        fw_addr[k] = 7'($urandom_range(0, 7));
      end
      fw_valid = 4'($urandom);
      odd_reg_write_wb = 1'($urandom); odd_rt_addr_wb = 7'($urandom_range(0, 7));
      odd_rt_wb = rand_qw();
      even_reg_write_wb = 1'($urandom); even_rt_addr_wb = 7'($urandom_range(0, 7));
      even_rt_wb = rand_qw();
      tick();
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/odd_rf_fwd.md
# odd_rf_fwd

Register-fetch / forwarding stage for the odd pipe. Holds the 128 × 128-bit register table, captures one decoded odd-pipe instruction per cycle and reads its three source operands. Resolves read-after-write hazards by forwarding from in-flight pipe stages and same-cycle writebacks. Presents the registered instruction and operand values to the local-store stage one cycle later.

## Interface
Parameters:
- FW_SRCS, 4, number of in-flight forwarding taps; index 0 is the youngest.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold all output registers and ignore the new instruction; register table writes still happen.
- branch_taken  in  1  flush: the next captured output becomes a nop.
- op_in  in  11 [0:10]  decoded opcode.
- format_in  in  3 [2:0]  instruction format.
- imm_in  in  18 [0:17]  immediate value.
- rt_addr_in  in  7 [0:6]  destination register.
- reg_write_in  in  1  instruction writes the register table.
- ra_addr, rb_addr, rc_addr  in  7 each [0:6]  source addresses; rc is the store-data source.
- fw_data  in  FW_SRCS×128  in-flight results from the odd and even delay taps.
- fw_addr  in  FW_SRCS×7  destination address of each tap.
- fw_valid  in  FW_SRCS  tap holds a result that will be written.
- odd_rt_wb, even_rt_wb  in  128 each  writeback values.
- odd_rt_addr_wb, even_rt_addr_wb  in  7 each  writeback addresses.
- odd_reg_write_wb, even_reg_write_wb  in  1 each  writeback enables.
- op, format, imm, rt_addr, reg_write  out  same widths as the *_in ports  registered instruction fields.
- ra, rb, rt_st  out  128 each  resolved operand values.

## Operation
- Register table: 128 entries × 128 bits, all zero on reset.
  - Each cycle, even_rt_wb is written when even_reg_write_wb = 1.
  - Each cycle, odd_rt_wb is written when odd_reg_write_wb = 1.
  - If both ports target the same address in the same cycle, the odd value is stored.
- Operand resolution, done independently for ra/rb/rc. First match wins:
  1. Lowest index k with fw_valid[k] = 1 and fw_addr[k] equal to the source address → fw_data[k].
  2. Odd writeback enabled to the same address → odd_rt_wb.
  3. Even writeback enabled to the same address → even_rt_wb.
  4. Register table contents.
- Register 0 is an ordinary register; there is no hard-wired zero.
- Output register update:
  - stall = 1: every output holds its value. branch_taken is ignored that cycle.
  - else branch_taken = 1: op = 0, format = 0, reg_write = 0, rt_addr = 0, imm = 0, ra/rb/rt_st = 0.
  - else: capture all *_in fields plus the three resolved operands.
- No validity decoding is done here. An unsupported op/format passes through unchanged; the downstream stage cancels it.

## Timing
- Reset (reset = 0, asynchronous): every output is 0. This encodes the nop op = 0, format = 0, so no spurious store follows reset. Register table is cleared.
- Reset asserted mid-operation: the register table and outputs clear at once. The first instruction after release is captured on the first rising edge with reset = 1.
- Latency: instruction presented in cycle N appears on the outputs after edge N+1.
- Write-through: a writeback in cycle N is visible to a read in cycle N (via priorities 2/3) and to the table from cycle N+1 on.
- Stall held for M cycles: the outputs stay frozen for M cycles. The upstream stage re-presents the same instruction, which is captured on the first edge with stall = 0. Forwarding is re-evaluated at that edge.

## Structure
- Shared package `spu_pkg`:
  - constants REG_COUNT = 128, QW_BITS = 128, REG_ADDR_BITS = 7;
  - the nop encoding (op = 0, format = 0);
  - typedefs qword_t and reg_addr_t.
- One sub-module `fwd_mux`: a parameterised priority selector, instantiated three times (ra, rb, rc).
  - Inputs: source address, tap vectors, both writeback ports, table read value.
  - Output: the resolved qword.

## Test plan
- Reset with the outputs previously non-zero → all outputs 0 asynchronously. After release, reading reg 5 gives 0.
- odd writeback reg 10 = 0xAAAA… with ra_addr = 10 in the same cycle → ra = 0xAAAA… one cycle later. A later read without writeback also returns 0xAAAA….
- fw_valid = 4'b0110, fw_addr[1] = fw_addr[2] = 20, fw_data[1] = 1, fw_data[2] = 2, rb_addr = 20 → rb = 1.
- even and odd writeback both to reg 30 (values 3 and 4) → next-cycle read of 30 returns 4.
- branch_taken with a stqd instruction on the inputs → next outputs: op = 0, format = 0, reg_write = 0, rt_st = 0.
- stall held 3 cycles while the inputs change → outputs unchanged. A register written during the stall is returned for the instruction captured after stall drops.
